ts_out_if: RTL and testbench
============================

TS_OUT_IF -- requirements
Module: ts_out_if

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning output FIFO depth in bytes (power of 2, minimum 8).
REQ-002 SHALL have parameter AFULL_MARGIN, default 6, meaning free-entry margin that covers read-path latency.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port ts_int, input, 1 bit: one-cycle pulse from the deinterleave buffer indicating a block is ready to read.
REQ-006 SHALL have port ts_overflow, input, 1 bit: buffer overrun; aborts the current block.
REQ-007 SHALL have port blk_len, input, 17 bits: bytes per block, sampled on ts_int.
REQ-008 SHALL have port ts_en_out, input, 1 bit: strobe marking ts_dout valid.
REQ-009 SHALL have port ts_dout, input, 8 bits: read data byte.
REQ-010 SHALL have port ts_ready, input, 1 bit: downstream accepts a byte.
REQ-011 SHALL have port ts_en_rd, output, 1 bit: level read request to the buffer; one byte returned per asserted cycle.
REQ-012 SHALL have port ts_valid, output, 1 bit: ts_data valid.
REQ-013 SHALL have port ts_sync, output, 1 bit: ts_data is byte 0 of a 188-byte TS packet.
REQ-014 SHALL have port ts_data, output, 8 bits: output byte.
REQ-015 SHALL have port blk_done, output, 1 bit: one-cycle pulse when a block is fully delivered.
REQ-016 SHALL have port fifo_ovf, output, 1 bit: sticky flag indicating a byte was dropped on FIFO full.
REQ-017 SHALL have port ts_err, output, 1 bit: one-cycle pulse on TS sync mismatch.

Function
REQ-018 FSM SHALL have states IDLE, READ, DRAIN, encoded one-hot.
- IDLE -> READ on ts_int.
- READ -> DRAIN when req_cnt reaches len_reg.
- DRAIN -> IDLE when rcv_cnt == len_reg and the FIFO is empty.
REQ-019 On ts_int in IDLE, the block SHALL latch blk_len into len_reg, clear req_cnt, rcv_cnt and pkt_cnt, and clear fifo_ovf.
REQ-020 ts_en_rd SHALL be registered and SHALL equal: state READ, AND req_cnt < len_reg, AND (FIFO count + in-flight bytes) <= FIFO_DEPTH - AFULL_MARGIN.
REQ-021 req_cnt SHALL increment on each cycle ts_en_rd is 1.
REQ-022 In-flight count SHALL equal req_cnt - rcv_cnt, at 17-bit width.
REQ-023 On each ts_en_out cycle, rcv_cnt SHALL increment and ts_dout SHALL be pushed to the FIFO.
- If the FIFO is full, the byte SHALL be dropped and fifo_ovf set; rcv_cnt still increments.
REQ-024 ts_en_out SHALL be ignored in IDLE.
REQ-025 The output SHALL use a valid/ready handshake.
- ts_valid = FIFO not empty; ts_data = FIFO head.
- A pop occurs when ts_valid & ts_ready.
- Push and pop in the same cycle SHALL keep the count unchanged, including when the FIFO is full.
REQ-026 pkt_cnt (0..187) SHALL advance on each pop and wrap 187 -> 0; ts_sync = ts_valid & (pkt_cnt == 0).
REQ-027 blk_done SHALL pulse for one cycle on the DRAIN -> IDLE transition.
REQ-028 ts_overflow in READ or DRAIN SHALL force IDLE on the next cycle, drop ts_en_rd, flush the FIFO and clear counters; blk_done SHALL NOT pulse.
REQ-029 ts_overflow in IDLE SHALL have no effect.
REQ-030 ts_int received in READ or DRAIN SHALL be ignored.
REQ-031 A block with blk_len == 0 SHALL go IDLE -> READ -> DRAIN -> IDLE with no request and SHALL pulse blk_done.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits.

Reset
REQ-033 On reset_n low, the block SHALL asynchronously reach the following state:
- FSM = IDLE.
- All counters and FIFO pointers = 0.
- ts_en_rd, ts_valid, ts_sync, blk_done, ts_err, fifo_ovf = 0; ts_data = 0x00.
REQ-034 Reset asserted mid-block SHALL discard all buffered data; after release the block SHALL wait for a fresh ts_int.

Configuration
REQ-035 Macro TS_OUT_IF_SYNC_CHECK_EN SHALL control TS sync checking.
- Defined: on a pop with pkt_cnt == 0 and ts_data != 0x47, the byte SHALL be popped with ts_sync=0 and ts_err SHALL pulse. The block then SHALL hunt: it discards bytes (pops with ts_valid forced 0, ignoring ts_ready) until the FIFO head is 0x47, then resumes with pkt_cnt = 0.
- Undefined: no check is made, ts_err SHALL be tied 0, and pkt_cnt is free-running.

Verification
REQ-036 blk_len=376, ts_ready=1, returns 3 cycles after requests: exactly 376 bytes out, ts_sync on bytes 0 and 188, one blk_done, fifo_ovf=0.
REQ-037 blk_len=376, ts_ready toggled 1-of-4: ts_en_rd throttles and the FIFO never overflows; output order matches input; fifo_ovf=0.
REQ-038 ts_overflow pulsed after 100 bytes received: the block is in IDLE next cycle, ts_valid=0 within 1 cycle, no blk_done; the next ts_int block of 188 completes normally.
REQ-039 ts_en_out injected with the FIFO full and ts_ready=0: the byte is dropped and fifo_ovf=1 until the next ts_int.
REQ-040 With the macro defined, the first packet starts with 0x46: ts_err is pulsed once; output resumes at the next 0x47 with ts_sync=1.
REQ-041 reset_n asserted mid-DRAIN: all outputs are 0 immediately; the next block after ts_int is correct.

Source files
------------

// File: rtl/ts_out_if.sv
// TS output interface: reads a block from the deinterleave buffer into a small FIFO and streams it
// on a valid/ready port. Optional TS sync checking is enabled by defining TS_OUT_IF_SYNC_CHECK_EN.
module ts_out_if #(
   parameter int FIFO_DEPTH   = 16,
   parameter int AFULL_MARGIN = 6
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ts_int,
   input  logic        ts_overflow,
   input  logic [16:0] blk_len,
   input  logic        ts_en_out,
   input  logic [7:0]  ts_dout,
   input  logic        ts_ready,
   output logic        ts_en_rd,
   output logic        ts_valid,
   output logic        ts_sync,
   output logic [7:0]  ts_data,
   output logic        blk_done,
   output logic        fifo_ovf,
   output logic        ts_err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;
   typedef enum logic [2:0] {IDLE = 3'b001, READ = 3'b010, DRAIN = 3'b100} state_t;

   localparam cnt_t        FULL_CNT  = cnt_t'(FIFO_DEPTH);
   localparam logic [16:0] FILL_MAX  = 17'(FIFO_DEPTH - AFULL_MARGIN);
   localparam logic [7:0]  SYNC_BYTE = 8'h47;
   localparam logic [7:0]  PKT_LAST  = 8'd187;

   state_t      state_r;
   logic [16:0] len_r, req_cnt_r, rcv_cnt_r;
   logic [7:0]  pkt_cnt_r;
   ptr_t        wr_ptr_r, rd_ptr_r;
   cnt_t        cnt_r;
   logic        en_rd_r, done_r, ovf_r;
   logic [7:0]  mem_r [FIFO_DEPTH];

   logic        empty_s, full_s, abort_s, start_s, push_evt_s, push_ok_s, drop_s;
   logic        valid_s, sync_s, pop_s, pkt_adv_s;
   logic [7:0]  head_s;
   cnt_t        cnt_nxt_s;
   logic [16:0] req_nxt_s, rcv_nxt_s, fill_s;

   assign head_s     = mem_r[rd_ptr_r];
   assign empty_s    = (cnt_r == cnt_t'(0));
   assign full_s     = (cnt_r == FULL_CNT);
   assign abort_s    = ts_overflow && (state_r != IDLE);
   assign start_s    = ts_int && (state_r == IDLE);
   assign push_evt_s = ts_en_out && (state_r != IDLE);
   // A full FIFO still accepts a byte when the head leaves in the same cycle
   assign push_ok_s  = push_evt_s && (!full_s || pop_s);
   assign drop_s     = push_evt_s && full_s && !pop_s;
   assign cnt_nxt_s  = cnt_r + cnt_t'(push_ok_s) - cnt_t'(pop_s);
   assign req_nxt_s  = req_cnt_r + 17'(en_rd_r);
   assign rcv_nxt_s  = rcv_cnt_r + 17'(push_evt_s);
   // Occupancy plus bytes still in flight, evaluated for the cycle the request would be issued
   assign fill_s     = 17'(cnt_nxt_s) + (req_nxt_s - rcv_nxt_s);

`ifdef TS_OUT_IF_SYNC_CHECK_EN
   logic hunt_r, err_r, head_ok_s, hunt_pop_s, sync_err_s;

   assign head_ok_s  = (head_s == SYNC_BYTE);
   assign valid_s    = !empty_s && !(hunt_r && !head_ok_s);
   assign hunt_pop_s = hunt_r && !empty_s && !head_ok_s;
   assign sync_err_s = valid_s && ts_ready && (pkt_cnt_r == 8'd0) && !head_ok_s;
   assign pop_s      = (valid_s && ts_ready) || hunt_pop_s;
   assign pkt_adv_s  = valid_s && ts_ready && !sync_err_s;
   assign sync_s     = valid_s && (pkt_cnt_r == 8'd0) && head_ok_s;
   assign ts_err     = err_r;

   // Sync hunt state and error pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hunt_r <= 1'b0;
         err_r  <= 1'b0;
      end else if (abort_s || start_s) begin
         hunt_r <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         err_r <= sync_err_s;
         if (sync_err_s)
            hunt_r <= 1'b1;
         else if (hunt_r && !empty_s && head_ok_s)
            hunt_r <= 1'b0;
         else
            hunt_r <= hunt_r;
      end
   end
`else
   assign valid_s   = !empty_s;
   assign pop_s     = valid_s && ts_ready;
   assign pkt_adv_s = pop_s;
   assign sync_s    = valid_s && (pkt_cnt_r == 8'd0);
   assign ts_err    = 1'b0;
`endif

   assign ts_en_rd = en_rd_r;
   assign ts_valid = valid_s;
   assign ts_sync  = sync_s;
   assign ts_data  = valid_s ? head_s : 8'h00;
   assign blk_done = done_r;
   assign fifo_ovf = ovf_r;

   // FIFO storage; contents need no reset because the pointers qualify them
   always_ff @(posedge clk) begin
      if (push_ok_s)
         mem_r[wr_ptr_r] <= ts_dout;
   end

   // Block FSM, read request, counters and FIFO pointers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         len_r     <= 17'd0;
         req_cnt_r <= 17'd0;
         rcv_cnt_r <= 17'd0;
         pkt_cnt_r <= 8'd0;
         wr_ptr_r  <= ptr_t'(0);
         rd_ptr_r  <= ptr_t'(0);
         cnt_r     <= cnt_t'(0);
         en_rd_r   <= 1'b0;
         done_r    <= 1'b0;
         ovf_r     <= 1'b0;
      end else if (abort_s) begin
         state_r   <= IDLE;
         req_cnt_r <= 17'd0;
         rcv_cnt_r <= 17'd0;
         pkt_cnt_r <= 8'd0;
         wr_ptr_r  <= ptr_t'(0);
         rd_ptr_r  <= ptr_t'(0);
         cnt_r     <= cnt_t'(0);
         en_rd_r   <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r    <= 1'b0;
         en_rd_r   <= (state_r == READ) && (req_nxt_s < len_r) && (fill_s <= FILL_MAX);
         req_cnt_r <= req_nxt_s;
         rcv_cnt_r <= rcv_nxt_s;
         wr_ptr_r  <= wr_ptr_r + ptr_t'(push_ok_s);
         rd_ptr_r  <= rd_ptr_r + ptr_t'(pop_s);
         cnt_r     <= cnt_nxt_s;
         if (pkt_adv_s)
            pkt_cnt_r <= (pkt_cnt_r == PKT_LAST) ? 8'd0 : pkt_cnt_r + 8'd1;
         if (drop_s)
            ovf_r <= 1'b1;
         case (state_r)
            IDLE: begin
               if (ts_int) begin
                  state_r   <= READ;
                  len_r     <= blk_len;
                  req_cnt_r <= 17'd0;
                  rcv_cnt_r <= 17'd0;
                  pkt_cnt_r <= 8'd0;
                  ovf_r     <= 1'b0;
               end
            end
            READ: begin
               if (req_cnt_r == len_r)
                  state_r <= DRAIN;
            end
            DRAIN: begin
               if ((rcv_cnt_r == len_r) && empty_s) begin
                  state_r <= IDLE;
                  done_r  <= 1'b1;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ts_out_if.sv
// Directed bench for ts_out_if: a 3-cycle-latency buffer model feeds the block and a negedge
// monitor checks every popped byte and sync flag against hand-computed packet contents.
module tb_ts_out_if;
   logic        clk;
   logic        reset_n, ts_int, ts_overflow, ts_en_out, ts_ready;
   logic [16:0] blk_len;
   logic [7:0]  ts_dout;
   logic        ts_en_rd, ts_valid, ts_sync, blk_done, fifo_ovf, ts_err;
   logic [7:0]  ts_data;

   int n_chk = 0;
   int n_pass = 0;

   int         src_idx, cyc, ready_mode;
   logic       src_on, inj_en, bad_mode;
   logic [7:0] inj_data;
   logic [3:0] dly;

   int pop_total, sync_total, done_total, err_total;
   int mon_base, sync_base, done_base, err_base;

   ts_out_if #(.FIFO_DEPTH(16), .AFULL_MARGIN(6)) dut (
      .clk(clk), .reset_n(reset_n), .ts_int(ts_int), .ts_overflow(ts_overflow),
      .blk_len(blk_len), .ts_en_out(ts_en_out), .ts_dout(ts_dout), .ts_ready(ts_ready),
      .ts_en_rd(ts_en_rd), .ts_valid(ts_valid), .ts_sync(ts_sync), .ts_data(ts_data),
      .blk_done(blk_done), .fifo_ovf(fifo_ovf), .ts_err(ts_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Byte k of a block: 0x47 at each packet start, never 0x47 elsewhere
   function automatic logic [7:0] src_byte(input int k);
      int p;
      p = k % 188;
      if (bad_mode && k == 0) return 8'h46;
      if (p == 0) return 8'h47;
      return 8'(p) ^ 8'h80;
   endfunction

   function automatic logic [7:0] exp_byte(input int i);
      if (bad_mode) return (i == 0) ? 8'h46 : src_byte(187 + i);
      return src_byte(i);
   endfunction

   function automatic logic exp_sync(input int i);
      if (bad_mode) return (i != 0) && ((187 + i) % 188 == 0);
      return (i % 188 == 0);
   endfunction

   // Deinterleave buffer model: returns one byte 3 cycles after each counted request
   initial begin
      ts_en_out = 1'b0; ts_dout = 8'h00; ts_ready = 1'b0;
      dly = 4'd0; cyc = 0; src_idx = 0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (!src_on) begin
            dly = 4'd0;
            src_idx = 0;
         end else begin
            dly = {dly[2:0], ts_en_rd};
         end
         if (ready_mode == 0) ts_ready = 1'b1;
         else if (ready_mode == 1) ts_ready = (cyc % 4 == 0);
         else ts_ready = 1'b0;
         if (inj_en) begin
            ts_en_out = 1'b1; ts_dout = inj_data;
         end else if (src_on && dly[3]) begin
            ts_en_out = 1'b1; ts_dout = src_byte(src_idx); src_idx++;
         end else begin
            ts_en_out = 1'b0; ts_dout = 8'h00;
         end
      end
   end

   // Output monitor
   initial begin
      pop_total = 0; sync_total = 0; done_total = 0; err_total = 0;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (ts_valid && ts_ready) begin
               check("pop_data", 32'(ts_data), 32'(exp_byte(pop_total - mon_base)));
               check("pop_sync", 32'(ts_sync), 32'(exp_sync(pop_total - mon_base)));
               if (ts_sync) sync_total++;
               pop_total++;
            end
            if (blk_done) done_total++;
            if (ts_err) err_total++;
         end
      end
   end

   task automatic start_block(input logic [16:0] len, input int mode, input logic use_src);
      @(negedge clk);
      ready_mode = mode; src_on = use_src;
      mon_base = pop_total; sync_base = sync_total; done_base = done_total; err_base = err_total;
      blk_len = len; ts_int = 1'b1;
      @(negedge clk);
      ts_int = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      for (int c = 0; c < limit && done_total == done_base; c++) @(negedge clk);
      repeat (5) @(negedge clk);
   endtask

   task automatic end_block(input string tag, input int n_out, input int n_sync, input int n_err);
      check({tag, "_bytes"}, pop_total - mon_base, n_out);
      check({tag, "_syncs"}, sync_total - sync_base, n_sync);
      check({tag, "_done"}, done_total - done_base, 1);
      check({tag, "_ovf"}, 32'(fifo_ovf), 32'd0);
      check({tag, "_err"}, err_total - err_base, n_err);
      src_on = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_en_rd"}, 32'(ts_en_rd), 32'd0);
      check({tag, "_valid"}, 32'(ts_valid), 32'd0);
      check({tag, "_sync"}, 32'(ts_sync), 32'd0);
      check({tag, "_data"}, 32'(ts_data), 32'd0);
      check({tag, "_done"}, 32'(blk_done), 32'd0);
      check({tag, "_fovf"}, 32'(fifo_ovf), 32'd0);
      check({tag, "_err"}, 32'(ts_err), 32'd0);
   endtask

   initial begin
      reset_n = 1'b0; ts_int = 1'b0; ts_overflow = 1'b0; blk_len = 17'd0;
      src_on = 1'b0; inj_en = 1'b0; inj_data = 8'h00; ready_mode = 0; bad_mode = 1'b0;
      mon_base = 0; sync_base = 0; done_base = 0; err_base = 0;
      repeat (3) @(negedge clk);
      check_all_zero("rst");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Full-rate block; a ts_int mid-block must be ignored
      start_block(17'd376, 0, 1'b1);
      repeat (40) @(negedge clk);
      blk_len = 17'd5; ts_int = 1'b1;
      @(negedge clk);
      ts_int = 1'b0;
      wait_done(3000);
      end_block("full", 376, 2, 0);

      // Downstream ready 1-of-4 forces read throttling
      start_block(17'd376, 1, 1'b1);
      wait_done(6000);
      end_block("thr", 376, 2, 0);

      // Buffer overflow after 100 bytes aborts the block
      start_block(17'd376, 1, 1'b1);
      for (int c = 0; c < 3000 && src_idx < 100; c++) @(negedge clk);
      check("abort_reached", 32'(src_idx >= 100), 32'd1);
      check("abort_pre_valid", 32'(ts_valid), 32'd1);
      ts_overflow = 1'b1; src_on = 1'b0;
      @(negedge clk);
      ts_overflow = 1'b0;
      check("abort_valid", 32'(ts_valid), 32'd0);
      check("abort_en_rd", 32'(ts_en_rd), 32'd0);
      repeat (20) @(negedge clk);
      check("abort_no_done", done_total - done_base, 0);
      start_block(17'd188, 0, 1'b1);
      wait_done(2000);
      end_block("post_abort", 188, 1, 0);

      // Unanswered requests stall at the margin; injected bytes fill the FIFO, the 17th drops
      start_block(17'd16, 2, 1'b0);
      repeat (20) @(negedge clk);
      check("inj_stall_en_rd", 32'(ts_en_rd), 32'd0);
      inj_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         inj_data = 8'(i + 16);
         @(negedge clk);
      end
      inj_en = 1'b0;
      repeat (2) @(negedge clk);
      check("inj_full_ovf", 32'(fifo_ovf), 32'd0);
      check("inj_valid", 32'(ts_valid), 32'd1);
      check("inj_head", 32'(ts_data), 32'h10);
      inj_en = 1'b1; inj_data = 8'hEE;
      @(negedge clk);
      inj_en = 1'b0;
      repeat (2) @(negedge clk);
      check("inj_drop_ovf", 32'(fifo_ovf), 32'd1);
      check("inj_head_kept", 32'(ts_data), 32'h10);
      ts_overflow = 1'b1;
      @(negedge clk);
      ts_overflow = 1'b0;
      @(negedge clk);
      check("ovf_sticky", 32'(fifo_ovf), 32'd1);
      check("ovf_flushed", 32'(ts_valid), 32'd0);

      // Zero-length block: clears fifo_ovf and completes without requests
      start_block(17'd0, 0, 1'b1);
      check("zero_ovf_clr", 32'(fifo_ovf), 32'd0);
      wait_done(50);
      end_block("zero", 0, 0, 0);

      // Reset in DRAIN with bytes held in the FIFO
      start_block(17'd8, 2, 1'b1);
      repeat (30) @(negedge clk);
      check("drain_valid", 32'(ts_valid), 32'd1);
      check("drain_en_rd", 32'(ts_en_rd), 32'd0);
      reset_n = 1'b0;
      #1;
      check_all_zero("mid_rst");
      src_on = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      start_block(17'd188, 0, 1'b1);
      wait_done(2000);
      end_block("post_rst", 188, 1, 0);

`ifdef TS_OUT_IF_SYNC_CHECK_EN
      // First packet starts with 0x46: one error, hunt to byte 188
      bad_mode = 1'b1;
      start_block(17'd376, 0, 1'b1);
      wait_done(3000);
      end_block("hunt", 189, 1, 1);
      @(negedge clk);
      bad_mode = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
